// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-256 decryption round sequencer: FSM encoding and round constants.
// Optional watchdog build macro used by the controller: DEC_CTRL_TIMEOUT_EN.
package aes_dec_pkg;

    localparam int NR_AES256      = 14;
    localparam int ROUND_W        = 4;
    localparam int SB_TIMEOUT_DEF = 15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_ARK,
        ST_SHR,
        ST_SB_ISSUE,
        ST_SB_WAIT,
        ST_ARK,
        ST_IMC,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/aes_dec_watchdog.sv
// Sub-bytes watchdog: counts enabled cycles since the last clear; expire_o flags the LIMIT-th one.
// Zero-latency expire (combinational on the current count); no backpressure.
module aes_dec_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// AES-256 decryption round sequencer: initial AddRoundKey, NR-1 full inverse rounds, final round.
// Sub-bytes watchdog and sticky error exist only when DEC_CTRL_TIMEOUT_EN is defined.
module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR         = NR_AES256,
    parameter int SB_TIMEOUT = SB_TIMEOUT_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               sbox_ready_i,
    input  logic               sb_done_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               ld_en_o,
    output logic               shr_en_o,
    output logic               sb_start_o,
    output logic               ark_en_o,
    output logic               imc_en_o
);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               wd_clr, wd_en, wd_expire;

    assign round_o = round_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        ld_en_o    = 1'b0;
        shr_en_o   = 1'b0;
        sb_start_o = 1'b0;
        ark_en_o   = 1'b0;
        imc_en_o   = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                // A load during reset would be discarded, so keep the enable quiet too.
                if (start_i && sbox_ready_i && !reset_i) begin
                    ld_en_o = 1'b1;
                    round_d = ROUND_W'(NR);
                    state_d = ST_INIT_ARK;
                end
            end
            ST_INIT_ARK: begin
                ark_en_o = 1'b1;
                round_d  = ROUND_W'(NR - 1);
                state_d  = ST_SHR;
            end
            ST_SHR: begin
                shr_en_o = 1'b1;
                state_d  = ST_SB_ISSUE;
            end
            ST_SB_ISSUE: begin
                sb_start_o = 1'b1;
                wd_clr     = 1'b1;
                state_d    = ST_SB_WAIT;
            end
            ST_SB_WAIT: begin
                wd_en = 1'b1;
                // A response arriving on the expiry cycle still counts.
                if (sb_done_i) begin
                    state_d = ST_ARK;
                end else if (wd_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_ARK: begin
                ark_en_o = 1'b1;
                state_d  = (round_q == '0) ? ST_DONE : ST_IMC;
            end
            ST_IMC: begin
                imc_en_o = 1'b1;
                round_d  = round_q - ROUND_W'(1);
                state_d  = ST_SHR;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                busy_o = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DEC_CTRL_TIMEOUT_EN
    logic error_q, error_d;

    aes_dec_watchdog #(
        .LIMIT(SB_TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .expire_o(wd_expire)
    );

    assign error_d = error_q || (state_d == ST_ERR);
    assign error_o = error_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`else
    logic unused_wd;

    assign wd_expire = 1'b0;
    assign error_o   = 1'b0;
    assign unused_wd = wd_clr ^ wd_en ^ (SB_TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: an event scoreboard fed by a reference round schedule,
// plus a sub-bytes responder with programmable latency.
module tb_aes_dec_round_ctrl;

    localparam int K_LD   = 0;
    localparam int K_SHR  = 1;
    localparam int K_SBS  = 2;
    localparam int K_ARK  = 3;
    localparam int K_IMC  = 4;
    localparam int K_DONE = 5;

    typedef struct {
        int kind;
        int rnd;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic       sbox_ready_i = 1'b0;
    logic       sb_done_i = 1'b0;
    logic       busy_o, done_o, error_o;
    logic [3:0] round_o;
    logic       ld_en_o, shr_en_o, sb_start_o, ark_en_o, imc_en_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    ev_t  q[$];
    int   n_kind[6];
    int   sb_lat = 5;
    int   sb_hang = -1;
    int   sb_spur_cyc = -1;
    bit   sb_pend = 1'b0;
    int   sb_due = 0;

    aes_dec_round_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .sbox_ready_i(sbox_ready_i),
        .sb_done_i   (sb_done_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .round_o     (round_o),
        .ld_en_o     (ld_en_o),
        .shr_en_o    (shr_en_o),
        .sb_start_o  (sb_start_o),
        .ark_en_o    (ark_en_o),
        .imc_en_o    (imc_en_o)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference schedule of one block accepted at cycle t0 with sub-bytes latency lat.
    function automatic void push_block(input int t0, input int lat);
        int t;
        t = t0;
        q.push_back(ev_t'{K_LD, -1, t});
        t++;
        q.push_back(ev_t'{K_ARK, 14, t});
        t++;
        for (int r = 13; r >= 0; r--) begin
            q.push_back(ev_t'{K_SHR, r, t});
            t++;
            q.push_back(ev_t'{K_SBS, r, t});
            t += 1 + lat;
            q.push_back(ev_t'{K_ARK, r, t});
            t++;
            if (r != 0) begin
                q.push_back(ev_t'{K_IMC, r, t});
                t++;
            end
        end
        q.push_back(ev_t'{K_DONE, 0, t});
    endfunction

    // Sub-bytes responder: sb_done pulses lat cycles after the sb_start cycle.
    initial forever begin
        @(negedge clk);
        if (sb_start_o && int'(round_o) != sb_hang) begin
            sb_pend = 1'b1;
            sb_due  = cyc + sb_lat;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        sb_done_i = (sb_pend && cyc == sb_due) || (cyc == sb_spur_cyc);
        if (sb_pend && cyc == sb_due) sb_pend = 1'b0;
    end

    // Scoreboard monitor: every enable/done pulse must match the head of the expected queue.
    initial forever begin
        bit ev[6];
        int n;
        ev_t e;
        @(negedge clk);
        ev[K_LD]   = ld_en_o;
        ev[K_SHR]  = shr_en_o;
        ev[K_SBS]  = sb_start_o;
        ev[K_ARK]  = ark_en_o;
        ev[K_IMC]  = imc_en_o;
        ev[K_DONE] = done_o;
        n = int'(ld_en_o) + int'(shr_en_o) + int'(sb_start_o) + int'(ark_en_o) + int'(imc_en_o);
        if (n != 0) begin
            total++;
            if (n > 1) begin
                bad++;
                $display("FAIL enable_mutex cyc=%0d enables_high=%0d want 1", cyc, n);
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (ev[k]) begin
                n_kind[k]++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected kind=%0d cyc=%0d round=%0d want no event", k, cyc, round_o);
                end else begin
                    e = q.pop_front();
                    if (e.kind !== k || e.cyc !== cyc || (e.rnd >= 0 && e.rnd !== int'(round_o))) begin
                        bad++;
                        $display("FAIL sb_event got kind=%0d cyc=%0d round=%0d want kind=%0d cyc=%0d round=%0d",
                                 k, cyc, round_o, e.kind, e.cyc, e.rnd);
                    end
                end
            end
        end
    end

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int lat, output int t0);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        t0 = cyc;
        push_block(t0, lat);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_block();
        for (int i = 0; i < 600; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL block_timeout pending=%0d want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        start_i = 1'b1;
        sbox_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy_o, done_o, error_o, ld_en_o, shr_en_o, sb_start_o, ark_en_o, imc_en_o} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outputs got %b want 00000000",
                     {busy_o, done_o, error_o, ld_en_o, shr_en_o, sb_start_o, ark_en_o, imc_en_o});
        end
        total++;
        if (round_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_round got %0d want 0", round_o);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_nominal();
        int t0;
        int exp_n[6];
        exp_n = '{1, 14, 14, 15, 13, 1};
        for (int k = 0; k < 6; k++) n_kind[k] = 0;
        sb_lat = 5;
        pulse_start(5, t0);
        wait_block();
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || cyc !== t0 + 128) begin
            bad++;
            $display("FAIL nominal_busy_after got busy=%b cyc=%0d want busy=0 cyc=%0d", busy_o, cyc, t0 + 128);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (n_kind[k] !== exp_n[k]) begin
                bad++;
                $display("FAIL nominal_count kind=%0d got %0d want %0d", k, n_kind[k], exp_n[k]);
            end
        end
        total++;
        if (error_o !== 1'b0) begin
            bad++;
            $display("FAIL nominal_error got %b want 0", error_o);
        end
    endtask

    task automatic test_sbox_gate();
        int t0;
        sbox_ready_i = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL gate_busy got %b want 0", busy_o);
        end
        @(posedge clk);
        #1;
        sbox_ready_i = 1'b1;
        t0 = cyc;
        push_block(t0, 5);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_block();
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL gate_busy_after got %b want 0", busy_o);
        end
    endtask

    task automatic test_ignore();
        int t0;
        sb_lat = 5;
        pulse_start(5, t0);
        sb_spur_cyc = t0 + 11;
        wait_cycle(t0 + 30);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_cycle(t0 + 127);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        sb_spur_cyc = -1;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || ld_en_o !== 1'b0 || q.size() != 0) begin
            bad++;
            $display("FAIL ignore_after_done got busy=%b ld=%b pending=%0d want 0 0 0", busy_o, ld_en_o, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        sb_lat = 5;
        pulse_start(5, t0);
        wait_cycle(t0 + 59);
        reset_i = 1'b1;
        @(negedge clk);
        total++;
        if (round_o !== 4'd7 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre got round=%0d busy=%b want round=7 busy=1", round_o, busy_o);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        q.delete();
        sb_pend = 1'b0;
        @(negedge clk);
        total++;
        if ({busy_o, done_o, error_o, ld_en_o, shr_en_o, sb_start_o, ark_en_o, imc_en_o} !== 8'b0
            || round_o !== 4'd0) begin
            bad++;
            $display("FAIL midreset_idle got outs=%b round=%0d want 00000000 round=0",
                     {busy_o, done_o, error_o, ld_en_o, shr_en_o, sb_start_o, ark_en_o, imc_en_o}, round_o);
        end
        pulse_start(5, t0);
        wait_block();
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_rerun_busy got %b want 0", busy_o);
        end
    endtask

`ifdef DEC_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int t0;
        sb_hang = 13;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        t0 = cyc;
        q.push_back(ev_t'{K_LD, -1, t0});
        q.push_back(ev_t'{K_ARK, 14, t0 + 1});
        q.push_back(ev_t'{K_SHR, 13, t0 + 2});
        q.push_back(ev_t'{K_SBS, 13, t0 + 3});
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_cycle(t0 + 18);
        @(negedge clk);
        total++;
        if (busy_o !== 1'b1 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_last_wait got busy=%b error=%b want 1 0", busy_o, error_o);
        end
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || error_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err got busy=%b error=%b want 0 1", busy_o, error_o);
        end
        start_i = 1'b1;
        repeat (10) @(negedge clk);
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || error_o !== 1'b1 || q.size() != 0) begin
            bad++;
            $display("FAIL timeout_sticky got busy=%b error=%b pending=%0d want 0 1 0", busy_o, error_o, q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        sb_hang = -1;
        @(negedge clk);
        total++;
        if (error_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear got error=%b busy=%b want 0 0", error_o, busy_o);
        end
    endtask

    task automatic test_to_coincide();
        int t0;
        sb_lat = 15;
        pulse_start(15, t0);
        wait_block();
        @(negedge clk);
        total++;
        if (error_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL coincide got error=%b busy=%b want 0 0", error_o, busy_o);
        end
        sb_lat = 5;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_sbox_gate();
        test_ignore();
        test_reset_mid();
`ifdef DEC_CTRL_TIMEOUT_EN
        test_timeout();
        test_to_coincide();
`endif
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d want finish before limit", cyc);
        $fatal(1);
    end

endmodule

// File: doc/aes_dec_round_ctrl.md
Name: aes_dec_round_ctrl

Overview:
- Round sequencer for the AES-256 decryption datapath.
- Steps one 128-bit block through the initial AddRoundKey, NR-1 full inverse rounds and the final inverse round.
- Issues single-cycle enables to the InvShiftRows, AddRoundKey and InvMixColumns stages, and runs the start/ready handshake with the multi-cycle inv_subBytes unit.
- Gates all work on S-box table readiness.

Parameters:
- NR, 14, number of rounds; round index width is 4 bits.
- SB_TIMEOUT, 15, maximum cycles spent in SB_WAIT before an error (used only with the timeout feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to decrypt the block currently presented on the datapath input.
- sbox_ready  input  1  inv S-box table initialisation complete.
- sb_done  input  1  inv_subBytes output-ready.
- busy  output  1  high from acceptance until the done cycle inclusive.
- done  output  1  one-cycle pulse; datapath result valid.
- error  output  1  sticky sub-bytes timeout flag.
- round  output  4  current round index.
- ld_en  output  1  load datapath state register from the input block.
- shr_en  output  1  apply InvShiftRows.
- sb_start  output  1  one-cycle in_ready pulse to inv_subBytes.
- ark_en  output  1  apply AddRoundKey with the key at index round.
- imc_en  output  1  apply InvMixColumns.

Behaviour:
- Reset (synchronous, active-high): state IDLE, round=0, all outputs 0, error cleared, watchdog cleared. Asserting reset mid-operation aborts the block; all outputs are 0 from the next edge.
- FSM states: IDLE, INIT_ARK, SHR, SB_ISSUE, SB_WAIT, ARK, IMC, DONE, ERR.
- IDLE: start=1 and sbox_ready=1 are accepted: ld_en=1 this cycle, round<=NR, next state INIT_ARK. start with sbox_ready=0 is ignored and not latched. start in any other state is ignored.
- INIT_ARK: ark_en=1 with round=NR. Then round<=NR-1, next SHR.
- SHR: shr_en=1, next SB_ISSUE.
- SB_ISSUE: sb_start=1 for exactly one cycle, watchdog<=0, next SB_WAIT.
- SB_WAIT: hold until sb_done is sampled 1, then next ARK. sb_done seen in any other state is ignored.
- ARK: ark_en=1. If round!=0, next IMC. If round==0, next DONE.
- IMC: imc_en=1, round<=round-1, next SHR. The final round therefore has no IMC.
- DONE: done=1, busy=1, next IDLE. A new start is acceptable in the following IDLE cycle only, so there is no back-to-back acceptance in DONE.
- Enables are mutually exclusive; at most one of ld_en, shr_en, sb_start, ark_en, imc_en is high per cycle.
- busy=1 in every state except IDLE and ERR.
- Latency with sub-bytes latency L (sb_done high L cycles after the sb_start cycle):
  - done occurs 1 + 13*(4+L) + (3+L) + 1 cycles after the accept cycle (NR=14).
  - For L=5 that is cycle 127.

Optional Feature:
- Macro: DEC_CTRL_TIMEOUT_EN.
- Defined:
  - Watchdog increments each SB_WAIT cycle.
  - If it reaches SB_TIMEOUT without sb_done, next state is ERR: error<=1, busy=0, no enables.
  - ERR is left only by reset.
  - If sb_done and expiry coincide, sb_done wins and the FSM goes to ARK.
- Undefined: no watchdog logic; SB_WAIT waits indefinitely; error is tied 0; ERR is unreachable.

Decomposition:
- Shared package aes_dec_pkg:
  - FSM state encoding.
  - Constants NR_AES256=14 and ROUND_W=4.
  - Default SB_TIMEOUT.
- One natural sub-module, aes_dec_watchdog: counter with clear/enable/expire, instantiated only under DEC_CTRL_TIMEOUT_EN. Everything else is one FSM.

Test Plan:
- Reset then sbox_ready=1; pulse start with a sub-bytes model at L=5 -> ld_en at cycle 0, ark_en with round=14 at cycle 1, exactly 14 sb_start, 14 shr_en, 15 ark_en (rounds 14..0), 13 imc_en, done pulse at cycle 127, busy low at cycle 128.
- start held high with sbox_ready=0 for 20 cycles, then sbox_ready=1 -> no activity while sbox_ready is low; acceptance on the first cycle both are high.
- start re-pulsed mid-block and sb_done spuriously pulsed during an SHR cycle -> both ignored; enable sequence and cycle-127 done unchanged.
- reset asserted during SB_WAIT of round 7 -> next cycle IDLE, all outputs 0; a fresh start completes normally at cycle 127.
- DEC_CTRL_TIMEOUT_EN, SB_TIMEOUT=15, sub-bytes model never responds in round 13 -> error=1 and busy=0 after 15 SB_WAIT cycles; stays there until reset.
- DEC_CTRL_TIMEOUT_EN, sb_done arrives on the expiry cycle -> no error; next state ARK; block completes.
